// File: rtl/spike_aer_pkg.sv
// rtl/spike_aer_pkg.sv - shared constants and AER event type for the spike encoder
package spike_aer_pkg;

  localparam int N_NEURONS = 8;
  localparam int ADDR_W    = $clog2(N_NEURONS);
  localparam int TS_WIDTH  = 8;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [ADDR_W-1:0]   addr;
  } aer_event_t;

endpackage

// File: rtl/spike_aer_encoder_fifo.sv
// rtl/spike_aer_encoder_fifo.sv - first-word-fall-through FIFO for AER events
module aer_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Masking the head while empty keeps the outputs at zero after reset.
  assign dout  = empty ? T'('0) : mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// rtl/spike_aer_encoder.sv - serialises per-tick spike vectors into timestamped AER events
module spike_aer_encoder
  import spike_aer_pkg::aer_event_t;
#(
  parameter  int N_NEURONS  = spike_aer_pkg::N_NEURONS,
  parameter  int FIFO_DEPTH = 16,
  parameter  int TS_WIDTH   = spike_aer_pkg::TS_WIDTH,
  localparam int ADDR_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [ADDR_W-1:0]    ev_addr,
  output logic [TS_WIDTH-1:0]  ev_ts,
  output logic                 busy,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  logic [N_NEURONS-1:0]       pend_q, pend_d, pend_after;
  logic [TS_WIDTH-1:0]        pend_ts_q, pend_ts_d, ts_cnt_q, ts_cnt_d;
  logic                       overflow_q, overflow_d, busy_q, busy_d;
  logic [7:0]                 drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0]          low_idx;
  logic                       fifo_full, fifo_empty, fifo_pop, scan_push, accept, drop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  aer_event_t                 push_ev, head_ev;

  assign fifo_pop  = !fifo_empty && ev_ready;
  assign scan_push = (pend_q != '0) && (!fifo_full || fifo_pop);
  assign push_ev   = '{ts: pend_ts_q, addr: low_idx};

  always_comb begin
    low_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = ADDR_W'(i);
    end
  end

  // A vector is taken whenever the mask is empty once this cycle's push is applied,
  // which covers both the idle case and the last-bit-leaving case.
  always_comb begin
    pend_after = scan_push ? (pend_q & ~(N_NEURONS'(1) << low_idx)) : pend_q;
    accept     = spike_valid && (pend_after == '0);
    drop       = spike_valid && (spike_in != '0) && !accept;
    pend_d     = accept ? spike_in : pend_after;
    pend_ts_d  = accept ? ts_cnt_q : pend_ts_q;
    ts_cnt_d   = spike_valid ? ts_cnt_q + 1'b1 : ts_cnt_q;
    overflow_d = overflow_q || drop;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    busy_d     = (pend_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_ts_q  <= '0;
      ts_cnt_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_ts_q  <= pend_ts_d;
      ts_cnt_q   <= ts_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= busy_d;
    end
  end

  aer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (aer_event_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (scan_push),
    .din   (push_ev),
    .pop   (fifo_pop),
    .dout  (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ev_valid   = (fifo_count != '0);
  assign ev_addr    = head_ev.addr;
  assign ev_ts      = head_ev.ts;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb/tb_spike_aer_encoder.sv - directed scoreboard bench for spike_aer_encoder
module tb_spike_aer_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spike_in = '0;
  logic       spike_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_addr;
  logic [7:0] ev_ts;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_count;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] ts;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spike_aer_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .spike_valid (spike_valid),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_addr     (ev_addr),
    .ev_ts       (ev_ts),
    .busy        (busy),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v);
    spike_in    = v;
    spike_valid = 1'b1;
    step();
    spike_valid = 1'b0;
    spike_in    = '0;
  endtask

  task automatic expect_bits(input logic [7:0] v, input logic [7:0] ts);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) exp_q.push_back('{addr: 3'(i), ts: ts});
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || ev_valid || busy) && k < budget) begin
      step();
      k++;
    end
    check("drain_done", 32'(k < budget), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    spike_valid = 1'b0;
    spike_in    = '0;
    #1;
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_addr", ev_addr, 0);
    check("rst_ev_ts", ev_ts, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", ev_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_addr", ev_addr, mon_e.addr);
        check("ev_ts", ev_ts, mon_e.ts);
      end
    end
  end

  initial begin
    // Single vector: latency, ordering, busy timing
    do_reset();
    ev_ready = 1'b1;
    expect_bits(8'b1010_0100, 8'd0);
    strobe(8'b1010_0100);
    check("t1_valid_t0", ev_valid, 0);
    check("t1_busy_t0", busy, 1);
    step();
    check("t1_valid_t1", ev_valid, 1);
    check("t1_head_addr", ev_addr, 2);
    step();
    check("t1_busy_t2", busy, 1);
    step();
    check("t1_busy_t3", busy, 0);
    wait_drain(20);

    // Back-to-back single bits
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{addr: 3'd0, ts: 8'(i)});
      strobe(8'h01);
    end
    wait_drain(30);
    check("t2_drop_count", drop_count, 0);
    check("t2_overflow", overflow, 0);

    // Backpressure: FIFO fills with ts 0,1; ts 2 stays pending; five drops
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < 3) expect_bits(8'hFF, 8'(k));
      strobe(8'hFF);
      repeat (7) step();
    end
    check("t3_drop_count", drop_count, 5);
    check("t3_overflow", overflow, 1);
    check("t3_busy", busy, 1);
    check("t3_head_valid", ev_valid, 1);
    check("t3_head_ts", ev_ts, 0);
    ev_ready = 1'b1;
    wait_drain(100);
    check("t3_overflow_sticky", overflow, 1);
    check("t3_drop_count_end", drop_count, 5);

    // Zero vector while busy
    do_reset();
    ev_ready = 1'b1;
    expect_bits(8'hFF, 8'd0);
    strobe(8'hFF);
    check("t4_busy", busy, 1);
    strobe(8'h00);
    wait_drain(30);
    check("t4_drop_count", drop_count, 0);
    check("t4_overflow", overflow, 0);
    exp_q.push_back('{addr: 3'd0, ts: 8'd2});
    strobe(8'h01);
    wait_drain(10);

    // Timestamp wrap
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      exp_q.push_back('{addr: 3'd7, ts: 8'(i)});
      strobe(8'h80);
    end
    wait_drain(30);
    check("t5_drop_count", drop_count, 0);

    // Reset mid-drain discards everything
    do_reset();
    ev_ready = 1'b0;
    strobe(8'hFF);
    repeat (7) step();
    strobe(8'hFF);
    check("t6_busy_pre", busy, 1);
    check("t6_valid_pre", ev_valid, 1);
    do_reset();
    ev_ready = 1'b1;
    repeat (20) step();
    check("t6_valid_post", ev_valid, 0);
    check("t6_busy_post", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream stage of the time-multiplexed LIF neuron array. It takes the per-tick 8-bit spike vector and serialises every set bit into an Address-Event Representation (AER) word: neuron address plus tick timestamp. Events are buffered in a small FIFO and drained through a valid/ready handshake toward the output pins or a router. Loss under sustained backpressure is flagged and counted; it is never silent.

## Interface
- `N_NEURONS`, default 8: spike vector width. Sets `ADDR_W = $clog2(N_NEURONS)`.
- `FIFO_DEPTH`, default 16: event FIFO entries. Must be a power of two.
- `TS_WIDTH`, default 8: timestamp width, wraps modulo 2^TS_WIDTH.

Ports:
- `clk` in, 1: single clock.
- `rst_n` in, 1: reset, asynchronous assert, active-low.
- `spike_in` in, N_NEURONS: spike vector from the neuron array, bit i = neuron i.
- `spike_valid` in, 1: one-cycle strobe; `spike_in` is sampled this cycle and one tick elapses.
- `ev_valid` out, 1: FIFO head holds an event.
- `ev_ready` in, 1: consumer accepts the head event.
- `ev_addr` out, ADDR_W: head event neuron index.
- `ev_ts` out, TS_WIDTH: head event tick timestamp.
- `busy` out, 1: pending mask non-zero.
- `overflow` out, 1: sticky; a non-zero vector was dropped.
- `drop_count` out, 8: dropped non-zero vectors, saturates at 255.

## Operation
- **Tick counter `ts_cnt`:**
  - Increments on every `spike_valid`, whether the vector is accepted or dropped.
  - Wraps 2^TS_WIDTH−1 → 0.
  - An accepted vector is tagged with the pre-increment value.
- **Pending mask `pend` and tag `pend_ts`:**
  - Vector accepted when `spike_valid` && (`pend`==0, or `pend` has exactly one bit set and that bit is written to the FIFO this cycle).
  - On accept, `pend` ← `spike_in` and `pend_ts` ← `ts_cnt`.
- **Drop:**
  - Occurs when `spike_valid` && `spike_in`≠0 && not accepted.
  - Sets `overflow` and increments `drop_count` (saturating at 255); `pend` is unchanged.
  - A zero vector while busy is not a drop.
- **Scanner:**
  - Each cycle with `pend`≠0 and FIFO writable, pushes {`pend_ts`, lowest set index} and clears that bit.
  - Events therefore leave in ascending address order, at most one per cycle.
- **FIFO write-enable:** FIFO writable = count<FIFO_DEPTH, or a pop occurs in the same cycle (write when full plus pop is legal).
- **FIFO read side:**
  - First-word-fall-through: `ev_valid` = count≠0, and `ev_addr`/`ev_ts` reflect the head.
  - Pop on `ev_valid`&&`ev_ready`.
  - Push and pop together leave the count unchanged.
- **Handshake rule:** head data and `ev_valid` stay stable until popped; `ev_ready` may toggle freely.
- **Clearing `overflow`:** only reset clears it.

## Timing
- **Reset values:** `ev_valid`=0, `ev_addr`=0, `ev_ts`=0, `busy`=0, `overflow`=0, `drop_count`=0, `ts_cnt`=0, `pend`=0, FIFO empty.
  - Reset mid-operation discards all pending and buffered events immediately.
- **Latency:**
  - `spike_valid` sampled at edge t → `pend` loaded at t.
  - First event pushed at edge t+1, so `ev_valid` is high after edge t+1 (2-cycle latency).
- **Throughput:**
  - With an empty FIFO and `ev_ready`=1, k set bits drain in k cycles.
  - A new vector can be accepted on the same edge the last pending bit is pushed.
- **FIFO full with no pop:** scanner stalls and `pend` holds; upstream vectors are then dropped per the rule above.
- **`busy`:** registered; equals (`pend`≠0).

## Structure
- **Package `spike_aer_pkg`:**
  - Constants `N_NEURONS`, `ADDR_W`, `TS_WIDTH`.
  - Typedef `aer_event_t` = packed struct {ts, addr}.
- **Sub-module `aer_fifo`:**
  - Synchronous FWFT FIFO parameterised by depth and element type.
  - Ports `push`, `pop`, `full`, `empty`, `count`.
  - Same `clk`/`rst_n`.
- **Top level:** tick counter, pending register, priority encoder, drop logic.

## Test plan
1. **Single vector:** reset, `ev_ready`=1, `spike_in`=8'b1010_0100 with `spike_valid` → `ev_valid` rises 2 cycles later; events (addr,ts) = (2,0), (5,0), (7,0) on consecutive cycles; `busy` falls after the third push.
2. **Back-to-back single bits:** `spike_in`=8'h01 with `spike_valid` every cycle for 10 cycles → 10 events, addr 0, ts 0..9; no drops.
3. **Backpressure:** `ev_ready`=0, eight `spike_valid` pulses of 8'hFF spaced 8 cycles apart → FIFO holds 16 events (ts 0,1); later non-zero vectors dropped; `overflow`=1; `drop_count`=5. Then `ev_ready`=1 → 16 stored events followed by the 8 pending ones, addresses ascending within each ts.
4. **Zero vector while busy:** `spike_in`=8'h00 strobed while `busy`=1 → no drop, `drop_count` unchanged, `ts_cnt` still advances.
5. **Timestamp wrap:** 257 strobes of 8'h80 with `ev_ready`=1 → event 256 has ts=255 and event 257 has ts=0.
6. **Reset mid-drain:** assert `rst_n`=0 with the FIFO half-full and `pend`≠0 → all outputs return to reset values asynchronously; after release, no stale events appear.
